alu_bitserial_seq: RTL and testbench
====================================

ALU_BITSERIAL_SEQ -- requirements
Module: alu_bitserial_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present on a, b, op.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have ports a, b  input  WIDTH  operands.
REQ-007 SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 NAND, 11 NOR.
REQ-008 SHALL have port res  output  WIDTH  result word.
REQ-009 SHALL have port res_valid  output  1  res holds a completed result.
REQ-010 SHALL have port res_ready  input  1  consumer takes result.
REQ-011 SHALL have port busy  output  1  high in RUN state.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-014 On accept, SHALL latch a, b, op into internal registers, clear bit counter to 0, clear result register, go to RUN.
REQ-015 In RUN, each cycle SHALL evaluate one bit, LSB first: result bit[cnt] = f(op_q, a_q[cnt], b_q[cnt]) per REQ-007 encoding, then cnt+1.
REQ-016 When cnt == WIDTH-1 in RUN, SHALL write the final bit and go to DONE on that edge.
REQ-017 res_valid SHALL assert exactly WIDTH clock edges after the accept edge and be 1 only in DONE.
REQ-018 res SHALL be stable and equal to the full result throughout DONE; partial results in RUN SHALL be visible on res but are not valid.
REQ-019 In DONE, res_valid & res_ready SHALL return FSM to IDLE next edge; res retains its value until next accept.
REQ-020 In DONE, res_valid SHALL stay high indefinitely while res_ready is low.
REQ-021 Changes to a, b, op, in_valid during RUN or DONE SHALL have no effect.
REQ-022 No back-to-back accept: in_ready SHALL be 0 in the cycle res is consumed; next accept earliest one cycle later (IDLE).
REQ-023 res_ready outside DONE SHALL be ignored.
REQ-024 busy SHALL equal (state == RUN).

Reset
REQ-025 rst high SHALL immediately force state IDLE, counter 0, res 0, res_valid 0, busy 0, in_ready 1 (after release), independent of clk.
REQ-026 rst asserted mid-RUN or in DONE SHALL abort the operation; no res_valid pulse SHALL follow reset release.
REQ-027 First accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro ALU_SEQ_ZERO_FLAG_EN, when defined, SHALL add output zero (1 bit): registered, 1 in DONE iff res == 0, else 0; reset value 0.
REQ-029 Without ALU_SEQ_ZERO_FLAG_EN, port zero and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-030 a=0xA5, b=0x3C, op=00, res_ready=1 -> res=0x24, res_valid high 8 edges after accept for one cycle.
REQ-031 Same operands, op=01/10/11 sequentially -> res 0xBD, 0xDB, 0x42; in_ready low during RUN and DONE.
REQ-032 op=00, a=0xFF, b=0x0F, res_ready held low 20 cycles -> res_valid and res=0x0F held 20 cycles; a/b changed meanwhile without effect.
REQ-033 Accept, assert rst at cycle 4 of RUN -> all outputs 0 immediately; no res_valid after release; next request a=0x00,b=0x00,op=11 -> res=0xFF.
REQ-034 With ALU_SEQ_ZERO_FLAG_EN: a=0xF0, b=0x0F, op=00 -> res=0x00, zero=1; op=01 -> res=0xFF, zero=0.

Source files
------------

// File: rtl/alu_bitserial_seq.sv
// Bit-serial logic unit: evaluates AND/OR/NAND/NOR one bit per cycle, LSB first.
// Optional zero-result flag output is built when ALU_SEQ_ZERO_FLAG_EN is defined.
module alu_bitserial_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy,
`ifdef ALU_SEQ_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_set;
    logic             accept;
    logic             consume;
    logic             last_bit;
    logic             bit_val;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and neither side may retract valid.
    assign accept   = in_valid & in_ready;
    assign consume  = res_valid & res_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        bit_val = 1'b0;
        case (op_q)
            2'b00:   bit_val = a_q[cnt] & b_q[cnt];
            2'b01:   bit_val = a_q[cnt] | b_q[cnt];
            2'b10:   bit_val = ~(a_q[cnt] & b_q[cnt]);
            default: bit_val = ~(a_q[cnt] | b_q[cnt]);
        endcase
    end

    // Result word with the current bit merged in; higher bits are still zero.
    always_comb begin
        res_set      = res_q;
        res_set[cnt] = bit_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    if (consume) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= 2'b00;
            cnt   <= '0;
            res_q <= '0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= '0;
            res_q <= '0;
        end else if (state == RUN) begin
            res_q <= res_set;
            if (!last_bit) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (state == RUN && last_bit) begin
            zero_q <= (res_set == '0);
        end else if (state != DONE || consume) begin
            zero_q <= 1'b0;
        end
    end

    assign zero = zero_q;
`endif

    // in_ready is held low while rst is asserted so every output reads 0 in reset.
    assign in_ready  = (state == IDLE) & ~rst;
    assign res_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign res       = res_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Bench for alu_bitserial_seq: directed cases plus random traffic checked against a word-level model.
// Build with ALU_SEQ_ZERO_FLAG_EN defined to also exercise the zero flag.
module tb_alu_bitserial_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] res;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic         busy;
    logic [1:0]   dbg_state;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    int errors = 0;
    int checks = 0;
    logic [W-1:0] exp_q[$];

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .res       (res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
`ifdef ALU_SEQ_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] o);
        case (o)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return ~(x & y);
            default: return ~(x | y);
        endcase
    endfunction

    function automatic logic [W-1:0] low_bits(input logic [W-1:0] x, input int n);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) if (i < n) r[i] = x[i];
        return r;
    endfunction

    // m_left: bit-times still to compute; m_done: a finished result is waiting.
    int           m_left = 0;
    bit           m_done = 1'b0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_res  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = '0;
            exp_q.delete();
        end else if (m_done) begin
            if (res_ready) begin
                m_done = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (m_left > 0) begin
            m_left--;
            m_res = low_bits(m_word, W - m_left);
            if (m_left == 0) m_done = 1'b1;
        end else if (in_valid) begin
            m_word = alu_ref(a, b, op);
            m_left = W;
            m_res  = '0;
            exp_q.push_back(m_word);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("in_ready", in_ready, !rst && m_left == 0 && !m_done);
        check("busy", busy, m_left > 0);
        check("res_valid", res_valid, m_done);
        check("res", res, m_res);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("zero", zero, m_done && m_res == '0);
`endif
        if (res_valid && res_ready && !rst) begin
            if (exp_q.size() > 0) check("sb_res", res, exp_q[0]);
            else check("sb_empty", exp_q.size(), 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [1:0] xo,
                          input logic [W-1:0] lit, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_op", in_ready, 1);
        a = xa; b = xb; op = xo;
        in_valid  = 1'b1;
        res_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op = 2'($urandom_range(0, 3));
        n = 0;
        while (!res_valid && n < 40) begin
            check("in_ready_run", in_ready, 0);
            @(posedge clk); #1;
            n++;
            a = W'($urandom);
        end
        check("latency", n, W);
        check("res_lit", res, lit);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check("zero_lit", zero, lit == '0);
`endif
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            a = W'($urandom); b = W'($urandom); op = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            check("hold_valid", res_valid, 1);
            check("hold_res", res, lit);
            check("in_ready_done", in_ready, 0);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("consumed_valid", res_valid, 0);
        check("retained_res", res, lit);
        check("ready_after", in_ready, 1);
        res_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", res, 0);
        check("rst_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        run_op(8'hA5, 8'h3C, 2'b00, 8'h24, 0);
        run_op(8'hA5, 8'h3C, 2'b01, 8'hBD, 0);
        run_op(8'hA5, 8'h3C, 2'b10, 8'hDB, 0);
        run_op(8'hA5, 8'h3C, 2'b11, 8'h42, 0);
        run_op(8'hFF, 8'h0F, 2'b00, 8'h0F, 20);
        run_op(8'hF0, 8'h0F, 2'b00, 8'h00, 0);
        run_op(8'hF0, 8'h0F, 2'b01, 8'hFF, 0);

        // abort mid-run
        a = 8'h5A; b = 8'hC3; op = 2'b01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_res", res, 0);
        check("abort_valid", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("no_valid_after_abort", res_valid, 0);
        end
        run_op(8'h00, 8'h00, 2'b11, 8'hFF, 0);

        // random traffic with one reset in the middle
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            a         = W'($urandom);
            b         = W'($urandom);
            op        = 2'($urandom_range(0, 3));
            res_ready = ($urandom_range(0, 3) != 0);
            if (c == 300) rst = 1'b1;
            if (c == 302) rst = 1'b0;
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_idle", in_ready, 1);
        check("drain_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
